// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: pixel clock-enable, frame tick and vblank-only round-robin scheduling of game-logic requesters.
//   clk_in      100 MHz clock
//   rst_n       asynchronous active-low reset
//   vblank      VGA vertical blank level (clk_in domain)
//   req         requester ready-to-run
//   done        one-cycle completion pulse from the granted requester
//   cfg_we      period write strobe
//   cfg_idx     requester index for period write
//   cfg_period  frames per step, 0 disables the requester
//   pix_ce      one-cycle enable every DIV clocks
//   frame_tick  one-cycle pulse per vblank rising edge
//   grant       one-hot grant, zero when idle
//   missed      sticky overrun flags
//   wdog_err    sticky watchdog error
// Define TICK_WDOG_EN to build the grant watchdog; otherwise a grant is held until done and wdog_err is 0.
module game_tick_scheduler #(
  parameter int N_REQ   = 3,
  parameter int DIV     = 4,
  parameter int FCNT_W  = 6,
  parameter int TIMEOUT = 4096,
  localparam int IDX_W  = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  done,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [FCNT_W-1:0] cfg_period,
  output logic              pix_ce,
  output logic              frame_tick,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  missed,
  output logic              wdog_err
);
  localparam int PIX_W = DIV > 2 ? $clog2(DIV) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(DIV - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  if (N_REQ < 1 || N_REQ > 8 || DIV < 2 || FCNT_W < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("game_tick_scheduler: parameter out of range");
  end
  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              vb_q, vb_d;
  logic              tick_q, tick_d;
  logic [FCNT_W-1:0] period_q [N_REQ];
  logic [FCNT_W-1:0] period_d [N_REQ];
  logic [FCNT_W-1:0] cnt_q [N_REQ];
  logic [FCNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [N_REQ-1:0]  missed_q, missed_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [N_REQ-1:0]  set, clr, elig;
  logic              wd_fire;
  // Closest eligible index after rr, wrapping; scanning far-to-near lets the nearest overwrite.
  function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] e, input logic [IDX_W-1:0] rr);
    logic [IDX_W-1:0] j;
    pick = rr;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IDX_W'((int'(rr) + k) % N_REQ);
      if (e[j]) pick = j;
    end
  endfunction
  always_comb begin
    pix_d    = pix_q == PIX_LAST ? '0 : pix_q + 1'b1;
    vb_d     = vblank;
    tick_d   = vblank & ~vb_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    set      = '0;
    clr      = '0;
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    if (cfg_we && int'(cfg_idx) < N_REQ) begin
      period_d[cfg_idx] = cfg_period;
      if (cfg_period == '0 && !grant_q[cfg_idx]) clr[cfg_idx] = 1'b1;
    end
    if (tick_q) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (period_q[i] != '0) begin
          set[i]   = cnt_q[i] == '0;
          cnt_d[i] = cnt_q[i] == '0 ? period_q[i] - 1'b1 : cnt_q[i] - 1'b1;
        end
      end
    end
    elig = pend_q & req;
    if (state_q == IDLE) begin
      if (vblank && |elig) begin
        rr_d    = pick(elig, rr_q);
        grant_d = N_REQ'(1) << rr_d;
        state_d = GRANT;
      end
    end else if (|(done & grant_q) || wd_fire) begin
      grant_d = '0;
      clr     = clr | grant_q;
      state_d = IDLE;
    end
    // A same-cycle clear (completion) absorbs a new set, so it is not an overrun.
    pend_d   = (pend_q & ~clr) | set;
    missed_d = missed_q | (set & pend_q & ~clr);
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pix_q    <= '0;
      vb_q     <= 1'b0;
      tick_q   <= 1'b0;
      for (int i = 0; i < N_REQ; i++) period_q[i] <= FCNT_W'(1);
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      pend_q   <= '0;
      missed_q <= '0;
      grant_q  <= '0;
      rr_q     <= IDX_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      vb_q     <= vb_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
    end
  end
`ifdef TICK_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wdog_q, wdog_d;
  // Counter is zero on entry to GRANT, so the grant lasts exactly TIMEOUT cycles.
  assign wd_fire = state_q == GRANT && wd_q == WD_W'(TIMEOUT - 1);
  always_comb begin
    wd_d   = state_q == GRANT ? wd_q + 1'b1 : '0;
    wdog_d = wdog_q | wd_fire;
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      wdog_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      wdog_q <= wdog_d;
    end
  end
  assign wdog_err = wdog_q;
`else
  assign wd_fire  = 1'b0;
  assign wdog_err = 1'b0;
`endif
  assign pix_ce     = pix_q == PIX_LAST;
  assign frame_tick = tick_q;
  assign grant      = grant_q;
  assign missed     = missed_q;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed checks of pix_ce, frame_tick, periodic scheduling, round-robin, vblank gating, overrun and watchdog.
module tb_game_tick_scheduler;
  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       vblank = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] done = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [5:0] cfg_period = '0;
  logic       pix_ce, frame_tick, wdog_err;
  logic [2:0] grant, missed;
  int         n_vec = 0;
  int         n_err = 0;
  int         fr, age, gcnt;
  bit         auto_done;
  logic [2:0] prev;
  logic [2:0] glog[$];
  int         flog[$];
  logic [2:0] seq3 [6];
  game_tick_scheduler #(.N_REQ(3), .DIV(4), .FCNT_W(6), .TIMEOUT(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .vblank(vblank), .req(req), .done(done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_period(cfg_period),
    .pix_ce(pix_ce), .frame_tick(frame_tick), .grant(grant), .missed(missed), .wdog_err(wdog_err)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock per iteration; logs grant rising values with frame number and echoes done two cycles into a grant.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_in);
      #1;
      if (grant != '0 && prev == '0) begin
        glog.push_back(grant);
        flog.push_back(fr);
      end
      if (grant != '0) gcnt++;
      prev = grant;
      if (grant != '0 && auto_done) begin
        age++;
        done = age == 2 ? grant : 3'b000;
      end else begin
        age = 0;
        done = '0;
      end
    end
  endtask
  task automatic frames(input int nf, input int hi, input int lo);
    for (int f = 0; f < nf; f++) begin
      fr++;
      vblank = 1'b1;
      run(hi);
      vblank = 1'b0;
      run(lo);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    vblank = 1'b0; req = '0; done = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_period = '0;
    glog.delete(); flog.delete();
    fr = 0; age = 0; gcnt = 0; prev = '0; auto_done = 1'b1;
    run(2);
    rst_n = 1'b1;
  endtask
  task automatic cfg(input logic [1:0] i, input logic [5:0] p);
    cfg_we = 1'b1; cfg_idx = i; cfg_period = p;
    run(1);
    cfg_we = 1'b0;
  endtask
  initial begin
    seq3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    chk("rst_pix_ce", pix_ce, 0);
    chk("rst_grant", grant, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_missed", missed, 0);
    chk("rst_wdog_err", wdog_err, 0);
    for (int k = 1; k <= 8; k++) begin
      run(1);
      chk($sformatf("pix_ce_edge%0d", k), pix_ce, k % 4 == 3);
    end
    chk("idle_frame_tick", frame_tick, 0);
    chk("idle_grant", grant, 0);
    vblank = 1'b1;
    run(1);
    chk("frame_tick_rise", frame_tick, 1);
    run(1);
    chk("frame_tick_pulse_end", frame_tick, 0);
    vblank = 1'b0;
    run(1);
    chk("frame_tick_fall", frame_tick, 0);
    do_reset();
    cfg(2'd1, 6'd0);
    cfg(2'd2, 6'd0);
    cfg(2'd0, 6'd3);
    req = 3'b001;
    frames(7, 10, 10);
    chk("p3_grant_count", glog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p3_grant%0d_value", i), glog[i], 3'b001);
      chk($sformatf("p3_grant%0d_frame", i), flog[i], 1 + 3 * i);
    end
    chk("p3_missed", missed, 0);
    do_reset();
    req = 3'b111;
    frames(2, 20, 4);
    chk("rr_grant_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), glog[i], seq3[i]);
    chk("rr_missed", missed, 0);
    do_reset();
    cfg(2'd0, 6'd0);
    cfg(2'd2, 6'd0);
    cfg(2'd1, 6'd2);
    req = 3'b010;
    frames(1, 1, 20);
    chk("vb_gate_grant", grant, 0);
    chk("vb_gate_count", glog.size(), 0);
    frames(1, 6, 4);
    chk("vb_resume_count", glog.size(), 1);
    chk("vb_resume_value", glog[0], 3'b010);
    chk("vb_resume_frame", flog[0], 2);
    chk("vb_missed", missed, 0);
`ifdef TICK_WDOG_EN
    do_reset();
    cfg(2'd0, 6'd0);
    cfg(2'd1, 6'd0);
    req = 3'b100;
    auto_done = 1'b0;
    frames(1, 30, 5);
    chk("wd_grant_cycles", gcnt, 16);
    chk("wd_grant_dropped", grant, 0);
    chk("wd_err", wdog_err, 1);
    chk("wd_grant_count", glog.size(), 1);
    chk("wd_missed", missed, 0);
`else
    do_reset();
    cfg(2'd0, 6'd0);
    cfg(2'd1, 6'd0);
    req = 3'b100;
    auto_done = 1'b0;
    frames(3, 10, 10);
    chk("ovr_missed", missed, 3'b100);
    chk("ovr_grant_held", grant, 3'b100);
    chk("ovr_grant_count", glog.size(), 1);
    chk("ovr_wdog_err", wdog_err, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_missed", missed, 0);
    rst_n = 1'b1;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
